hamming_secded_decoder16: RTL

// - Check/correct side of the Hamming-protected 16-bit counter: takes stored count + 6 check bits,

---
 rtl/hamming_secded_decoder16.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/hamming_secded_decoder16.sv
// Hamming SEC/DED decoder for the protected 16-bit counter word.
// Two register stages with valid/ready flow control: stage 1 captures the
// word and its syndrome, stage 2 holds the corrected word and its
// classification. Optional scrub write-back and saturating event counters.

module hamming_secded_decoder16 #(
   parameter int SCRUB_EN = 1,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   input  logic [5:0]       in_check,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,
   output logic [4:0]       out_syndrome,
   output logic             out_sec,
   output logic             out_ded,
   output logic             wb_valid,
   output logic [15:0]      wb_data,
   output logic [5:0]       wb_check,
   input  logic             cnt_clear,
   output logic [CNT_W-1:0] sec_count,
   output logic [CNT_W-1:0] ded_count
);

   localparam logic SCRUB_ON = (SCRUB_EN != 0);

   // Codeword position of data bit idx; powers of two are reserved for check bits.
   function automatic logic [4:0] data_pos(input int idx);
      case (idx)
         0:       return 5'd3;
         1:       return 5'd5;
         2:       return 5'd6;
         3:       return 5'd7;
         4:       return 5'd9;
         5:       return 5'd10;
         6:       return 5'd11;
         7:       return 5'd12;
         8:       return 5'd13;
         9:       return 5'd14;
         10:      return 5'd15;
         11:      return 5'd17;
         12:      return 5'd18;
         13:      return 5'd19;
         14:      return 5'd20;
         15:      return 5'd21;
         default: return 5'd0;
      endcase
   endfunction

   // The Hamming check bits are the XOR of the positions of all set data bits.
   function automatic logic [4:0] hamming_bits(input logic [15:0] d);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) begin
         if (d[i]) c = c ^ data_pos(i);
      end
      return c;
   endfunction

   // Full 6-bit check field: Hamming bits plus even overall parity over all 22 bits.
   function automatic logic [5:0] encode(input logic [15:0] d);
      logic [4:0] c;
      c = hamming_bits(d);
      return {(^d) ^ (^c), c};
   endfunction

   logic        s1_valid;
   logic [15:0] s1_data;
   logic [4:0]  s1_syn;
   logic        s1_par;
   logic        s1_open;
   logic        s2_adv;
   logic        out_xfer;
   logic [15:0] fix_data;
   logic        fix_sec;
   logic        fix_ded;
   logic [5:0]  wb_check_r;

   assign out_xfer = out_valid && out_ready;
   assign s2_adv   = !out_valid || out_ready;
   assign s1_open  = !s1_valid || s2_adv;
   assign in_ready = reset && s1_open;

   assign wb_valid = SCRUB_ON && out_xfer && out_sec;
   assign wb_data  = out_data;
   assign wb_check = wb_check_r;

   // Stage 1: capture the incoming word with its syndrome and overall parity.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_syn   <= '0;
         s1_par   <= 1'b0;
      end else if (s1_open) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data <= in_data;
            s1_syn  <= hamming_bits(in_data) ^ in_check[4:0];
            s1_par  <= (^in_data) ^ (^in_check);
         end
      end
   end

   // Classify the stage-1 word and flip the addressed data bit for a correctable error.
   always_comb begin
      fix_data = s1_data;
      fix_sec  = 1'b0;
      fix_ded  = 1'b0;
      if (s1_par) begin
         if (s1_syn <= 5'd21) begin
            fix_sec = 1'b1;
            for (int i = 0; i < 16; i++) begin
               if (s1_syn == data_pos(i)) fix_data[i] = ~s1_data[i];
            end
         end else begin
            fix_ded = 1'b1;
         end
      end else if (s1_syn != 5'd0) begin
         fix_ded = 1'b1;
      end
   end

   // Stage 2: hold the decoded word until the consumer takes it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_syndrome <= '0;
         out_sec      <= 1'b0;
         out_ded      <= 1'b0;
         wb_check_r   <= '0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data     <= fix_data;
            out_syndrome <= s1_syn;
            out_sec      <= fix_sec;
            out_ded      <= fix_ded;
            wb_check_r   <= encode(fix_data);
         end
      end
   end

   // Saturating event counters, bumped when a flagged word leaves; clear wins.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sec_count <= '0;
         ded_count <= '0;
      end else if (cnt_clear) begin
         sec_count <= '0;
         ded_count <= '0;
      end else begin
         if (out_xfer && out_sec && (sec_count != '1)) sec_count <= sec_count + CNT_W'(1);
         if (out_xfer && out_ded && (ded_count != '1)) ded_count <= ded_count + CNT_W'(1);
      end
   end

endmodule
